// File: rtl/hazard_pkg.sv
// Shared types for the RVX10 hazard controller: forwarding selects and sequencer states.
package hazard_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    MC_IDLE,
    MC_BUSY
  } mc_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle; master is the datapath, slave the hazard unit.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = hazard_pkg::REG_AW_DEF
) ();

  logic [REG_AW-1:0] rs1D, rs2D;
  logic [REG_AW-1:0] rs1E, rs2E, rdE;
  logic [REG_AW-1:0] rdM, rdW;
  logic              regwriteM, regwriteW;
  logic              loadE, pcsrcE, mc_startE;
  logic [1:0]        forwardAE, forwardBE;
  logic              stallF, stallD, stallE;
  logic              flushD, flushE, flushM;
  logic              mc_busy, mc_done;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, regwriteM, regwriteW,
           loadE, pcsrcE, mc_startE,
    input  forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE, flushM,
           mc_busy, mc_done
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, regwriteM, regwriteW,
           loadE, pcsrcE, mc_startE,
    output forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE, flushM,
           mc_busy, mc_done
  );

endinterface

// File: rtl/mc_seq.sv
// Multicycle-op sequencer: holds a long-latency op in E for MC_LATENCY cycles.
module mc_seq
  import hazard_pkg::*;
#(
  parameter int unsigned MC_LATENCY = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mc_start,
  output logic mc_stall,
  output logic mc_busy,
  output logic mc_done
);

  localparam int unsigned    CntW    = $clog2(MC_LATENCY);
  localparam logic [CntW-1:0] CntLoad = CntW'(MC_LATENCY - 2);

  mc_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            stall_c, done_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      MC_IDLE: begin
        if (mc_start) begin
          stall_c = 1'b1;
          cnt_d   = CntLoad;
          state_d = MC_BUSY;
        end
      end
      MC_BUSY: begin
        // mc_start is ignored here: the same op is still sitting in E.
        if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CntW'(1);
        end else begin
          done_c  = 1'b1;
          state_d = MC_IDLE;
        end
      end
    endcase
  end

  // Keep the pipeline quiet while reset is held, even if mc_start is still high.
  assign mc_stall = stall_c & reset_n;
  assign mc_done  = done_c & reset_n;
  assign mc_busy  = (state_q == MC_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// RVX10 5-stage hazard controller: forwarding, load-use stall, branch flush, multicycle hold.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned REG_AW     = REG_AW_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef HAZARD_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
`endif
  hazard_ctrl_if.slave hz
);

  function automatic fwd_sel_e fwd_sel(input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] rd_m,
                                       input logic [REG_AW-1:0] rd_w,
                                       input logic              we_m,
                                       input logic              we_w);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (rs != '0) begin
      if (we_m && (rd_m == rs))      sel = FWD_MEM;
      else if (we_w && (rd_w == rs)) sel = FWD_WB;
    end
    return sel;
  endfunction

  logic lw_stall, mc_stall;
  logic stall_fd, flush_d, flush_e;

  assign hz.forwardAE = fwd_sel(hz.rs1E, hz.rdM, hz.rdW, hz.regwriteM, hz.regwriteW);
  assign hz.forwardBE = fwd_sel(hz.rs2E, hz.rdM, hz.rdW, hz.regwriteM, hz.regwriteW);

  assign lw_stall = hz.loadE && (hz.rdE != '0) && ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

  mc_seq #(
    .MC_LATENCY(MC_LATENCY)
  ) u_mc_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .mc_start (hz.mc_startE),
    .mc_stall (mc_stall),
    .mc_busy  (hz.mc_busy),
    .mc_done  (hz.mc_done)
  );

  // A branch or load-use bubble in E only takes effect once E is free to advance.
  assign stall_fd = lw_stall || mc_stall;
  assign flush_e  = (lw_stall || hz.pcsrcE) && !mc_stall;
  assign flush_d  = hz.pcsrcE && !mc_stall;

  assign hz.stallF = stall_fd;
  assign hz.stallD = stall_fd;
  assign hz.stallE = mc_stall;
  assign hz.flushM = mc_stall;
  assign hz.flushE = flush_e;
  assign hz.flushD = flush_d;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_fd && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if ((flush_d || flush_e) && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (latency 4 and latency 2 instances).
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(5)) hif  ();
  hazard_ctrl_if #(.REG_AW(5)) hif2 ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;
`endif

  hazard_ctrl #(.MC_LATENCY(4), .REG_AW(5)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef HAZARD_PERF_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .hz        (hif.slave)
  );

  hazard_ctrl #(.MC_LATENCY(2), .REG_AW(5)) dut2 (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef HAZARD_PERF_EN
    .stall_cnt (stall_cnt2),
    .flush_cnt (flush_cnt2),
`endif
    .hz        (hif2.slave)
  );

  // {stallF, stallD, stallE, flushD, flushE, flushM, mc_busy, mc_done}
  logic [7:0] ctl, ctl2;
  assign ctl  = {hif.stallF, hif.stallD, hif.stallE, hif.flushD, hif.flushE, hif.flushM,
                 hif.mc_busy, hif.mc_done};
  assign ctl2 = {hif2.stallF, hif2.stallD, hif2.stallE, hif2.flushD, hif2.flushE, hif2.flushM,
                 hif2.mc_busy, hif2.mc_done};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    hif.rs1D = '0; hif.rs2D = '0; hif.rs1E = '0; hif.rs2E = '0; hif.rdE = '0;
    hif.rdM = '0; hif.rdW = '0; hif.regwriteM = 1'b0; hif.regwriteW = 1'b0;
    hif.loadE = 1'b0; hif.pcsrcE = 1'b0; hif.mc_startE = 1'b0;
    hif2.rs1D = '0; hif2.rs2D = '0; hif2.rs1E = '0; hif2.rs2E = '0; hif2.rdE = '0;
    hif2.rdM = '0; hif2.rdW = '0; hif2.regwriteM = 1'b0; hif2.regwriteW = 1'b0;
    hif2.loadE = 1'b0; hif2.pcsrcE = 1'b0; hif2.mc_startE = 1'b0;
  endtask

  // Leaves time 2 units after a rising edge, well clear of the next one.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    quiet();
    reset_n = 1'b0;
    #12;
    chk("reset_ctl", 32'(ctl), 32'h00);
    chk("reset_fwdA", 32'(hif.forwardAE), 32'h0);
    chk("reset_fwdB", 32'(hif.forwardBE), 32'h0);
    reset_n = 1'b1;
    cyc();

    // Forwarding priority and x0 handling
    hif.regwriteM = 1'b1; hif.rdM = 5'd5; hif.regwriteW = 1'b1; hif.rdW = 5'd5;
    hif.rs1E = 5'd5; hif.rs2E = 5'd5;
    #1 chk("fwdA_mem_prio", 32'(hif.forwardAE), 32'h2);
    chk("fwdB_mem_prio", 32'(hif.forwardBE), 32'h2);
    hif.regwriteM = 1'b0;
    #1 chk("fwdA_wb", 32'(hif.forwardAE), 32'h1);
    chk("fwdB_wb", 32'(hif.forwardBE), 32'h1);
    hif.regwriteM = 1'b1; hif.rs1E = 5'd0; hif.rdM = 5'd0; hif.rdW = 5'd0;
    #1 chk("fwdA_x0", 32'(hif.forwardAE), 32'h0);
    chk("fwdB_nomatch", 32'(hif.forwardBE), 32'h0);
    hif.rs1E = 5'd5; hif.rdW = 5'd5; hif.rs2E = 5'd3; hif.rdM = 5'd3;
    #1 chk("fwdA_split_wb", 32'(hif.forwardAE), 32'h1);
    chk("fwdB_split_mem", 32'(hif.forwardBE), 32'h2);

    // Load-use
    quiet();
    hif.loadE = 1'b1; hif.rdE = 5'd7; hif.rs2D = 5'd7;
    #1 chk("lw_stall", 32'(ctl), 32'hC8);
    hif.rdE = 5'd0; hif.rs2D = 5'd0;
    #1 chk("lw_x0_nostall", 32'(ctl), 32'h00);
    hif.loadE = 1'b0; hif.rdE = 5'd7; hif.rs1D = 5'd7;
    #1 chk("no_load_nostall", 32'(ctl), 32'h00);

    // Taken branch in an unstalled cycle
    quiet();
    hif.pcsrcE = 1'b1;
    #1 chk("branch_flush", 32'(ctl), 32'h18);
    quiet();

    // Multicycle op: latency 4 on dut, latency 2 on dut2
    cyc();
    hif.mc_startE = 1'b1; hif2.mc_startE = 1'b1;
    #1 chk("mc4_c0", 32'(ctl), 32'hE4);
    chk("mc2_c0", 32'(ctl2), 32'hE4);
    cyc();
    #1 chk("mc4_c1", 32'(ctl), 32'hE6);
    chk("mc2_c1_done", 32'(ctl2), 32'h03);
    hif2.mc_startE = 1'b0;
    cyc();
    #1 chk("mc4_c2", 32'(ctl), 32'hE6);
    chk("mc2_c2_idle", 32'(ctl2), 32'h00);
    cyc();
    #1 chk("mc4_c3_done", 32'(ctl), 32'h03);
    hif.mc_startE = 1'b0;
    cyc();
    #1 chk("mc4_c4_idle", 32'(ctl), 32'h00);

    // Branch held through the op resolves only on the done cycle
    hif.mc_startE = 1'b1; hif.pcsrcE = 1'b1;
    #1 chk("mcbr_c0", 32'(ctl), 32'hE4);
    for (int c = 1; c < 3; c++) begin
      cyc();
      #1 chk($sformatf("mcbr_c%0d", c), 32'(ctl), 32'hE6);
    end
    cyc();
    #1 chk("mcbr_done_flush", 32'(ctl), 32'h1B);
    quiet();
    cyc();
    #1 chk("mcbr_idle", 32'(ctl), 32'h00);

    // Asynchronous reset mid-op, then a full restart
    hif.mc_startE = 1'b1;
    cyc();
    #1 chk("rst_pre_busy", 32'(ctl), 32'hE6);
    reset_n = 1'b0;
    #1 chk("rst_async_quiet", 32'(ctl), 32'h00);
    cyc();
    reset_n = 1'b1;
    #1 chk("rst_restart_c0", 32'(ctl), 32'hE4);
    for (int c = 1; c < 3; c++) begin
      cyc();
      #1 chk($sformatf("rst_restart_c%0d", c), 32'(ctl), 32'hE6);
    end
    cyc();
    #1 chk("rst_restart_done", 32'(ctl), 32'h03);
    quiet();
    cyc();
    #1 chk("rst_restart_idle", 32'(ctl), 32'h00);

`ifdef HAZARD_PERF_EN
    reset_n = 1'b0;
    #1 chk("perf_reset", stall_cnt | flush_cnt, 32'h0);
    reset_n = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      quiet();
      if (i < 3) begin
        hif.loadE = 1'b1; hif.rdE = 5'd7; hif.rs1D = 5'd7;
      end else begin
        hif.pcsrcE = 1'b1;
      end
      cyc();
    end
    quiet();
    #1 chk("perf_stall_cnt", stall_cnt, 32'd3);
    chk("perf_flush_cnt", flush_cnt, 32'd5);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    hif.loadE = 1'b1; hif.rdE = 5'd7; hif.rs1D = 5'd7;
    cyc();
    #1 chk("perf_reach_max", stall_cnt, 32'hFFFF_FFFF);
    cyc();
    #1 chk("perf_saturate", stall_cnt, 32'hFFFF_FFFF);
    quiet();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
